// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXIS packet arbiters.
// Optional statistics are enabled with macro ARB_PKT_STATS_EN.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr.
// Scans upward from ptr and wraps at NUM_SRC-1 back to 0.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W:0] w_sum;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_sum = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_SRC)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_SRC);
            end
            if (req[w_sum[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter in front of a packet-mode AXIS FIFO.
// Define ARB_PKT_STATS_EN to add per-source completed-packet counters.
module axis_pkt_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int USER_W  = 1,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0] s_axis_tkeep,
    input  logic [NUM_SRC-1:0]        s_axis_tlast,
    input  logic [NUM_SRC*USER_W-1:0] s_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [KEEP_W-1:0]         m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [USER_W-1:0]         m_axis_tuser,
    input  logic                      fifo_prog_full,
`ifdef ARB_PKT_STATS_EN
    output logic [NUM_SRC*CNT_W-1:0]  pkt_cnt,
`endif
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic             w_xfer;
    logic             w_beat;
    logic             w_last_beat;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [DATA_W-1:0] w_sel_data;
    logic [KEEP_W-1:0] w_sel_keep;
    logic [USER_W-1:0] w_sel_user;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (s_axis_tvalid),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_win)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_user  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant_idx == IDX_W'(i)) begin
                w_sel_valid = s_axis_tvalid[i];
                w_sel_last  = s_axis_tlast[i];
                w_sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
                w_sel_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                w_sel_user  = s_axis_tuser[i*USER_W +: USER_W];
            end
        end
    end

    assign w_xfer      = (r_state == ST_XFER);
    assign w_beat      = m_axis_tvalid & m_axis_tready;
    assign w_last_beat = w_beat & m_axis_tlast;
    assign w_ptr_nxt   = (r_grant_idx == IDX_W'(NUM_SRC - 1)) ?
                         '0 : r_grant_idx + 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // prog_full only gates new grants; an open packet always finishes.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (!fifo_prog_full && w_found) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_valid   = w_xfer;
        grant_idx     = r_grant_idx;
        m_axis_tvalid = w_xfer & w_sel_valid;
        m_axis_tlast  = w_xfer & w_sel_last;
        m_axis_tdata  = w_xfer ? w_sel_data : '0;
        m_axis_tkeep  = w_xfer ? w_sel_keep : '0;
        m_axis_tuser  = w_xfer ? w_sel_user : '0;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_axis_tready[i] = w_xfer & m_axis_tready &
                               (r_grant_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else begin
            if (r_state == ST_IDLE && w_state_nxt == ST_XFER) begin
                r_grant_idx <= w_win;
            end
            if (w_last_beat) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

`ifdef ARB_PKT_STATS_EN
    logic [CNT_W-1:0] r_pkt_cnt [NUM_SRC];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_last_beat && r_grant_idx == IDX_W'(i)) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pkt_cnt[i*CNT_W +: CNT_W] = r_pkt_cnt[i];
        end
    end
`endif

endmodule
